// File: rtl/shift_register_pkg.sv
// Shared definitions for the serial-in / parallel-out shift register.
package shift_register_pkg;

   // Smallest register that still has distinct entry and far-end stages.
   localparam int unsigned SR_MIN_WIDTH = 2;

   typedef enum logic {
      SHIFT_DIR_RIGHT = 1'b0,   // pi enters at MSB, data moves toward bit 0
      SHIFT_DIR_LEFT  = 1'b1    // pi enters at bit 0, data moves toward MSB
   } shift_dir_e;

   // Stage whose content falls off the register on the next shift.
   function automatic int unsigned far_index(input shift_dir_e dir, input int unsigned width);
      return (dir == SHIFT_DIR_LEFT) ? width - 1 : 0;
   endfunction

endpackage

// File: rtl/shift_register_stage.sv
// Single register stage: one D flop with synchronous reset to a per-bit value.
import shift_register_pkg::*;

module shift_stage #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   // Load the stage reset value on rst, otherwise capture d.
   always_ff @(posedge clk) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end

endmodule

// File: rtl/shift_register.sv
// Parameterised SIPO shift register with serial far-end output.
import shift_register_pkg::*;

module shift_register #(
   parameter int unsigned      WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               SHIFT_LEFT  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pi,
   output logic [WIDTH-1:0] q,
   output logic             so
);

   localparam shift_dir_e  DIR = SHIFT_LEFT ? SHIFT_DIR_LEFT : SHIFT_DIR_RIGHT;
   localparam int unsigned FAR = far_index(DIR, WIDTH);

   if (WIDTH < SR_MIN_WIDTH) begin : g_width_check
      $error("shift_register: WIDTH must be at least 2");
   end

   logic [WIDTH-1:0] d;

   // Next register contents: pi inserted at the entry end, everything moves one place.
   always_comb begin
      d = '0;
      if (DIR == SHIFT_DIR_LEFT) d = {q[WIDTH-2:0], pi};
      else                       d = {pi, q[WIDTH-1:1]};
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      shift_stage #(.RST_VAL(RESET_VALUE[i])) u_stage (
         .clk (clk),
         .rst (rst),
         .d   (d[i]),
         .q   (q[i])
      );
   end

   // Serial output captures the far-end bit as it is shifted out; clears on reset.
   shift_stage #(.RST_VAL(1'b0)) u_so (
      .clk (clk),
      .rst (rst),
      .d   (q[FAR]),
      .q   (so)
   );

endmodule

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register (left and right variants).
module tb_shift_register;

   logic        clk = 1'b0;
   logic        rst, pi, rst_r, pi_r;
   logic [15:0] q, q_r;
   logic        so, so_r;

   int unsigned total = 0;
   int unsigned bad   = 0;

   shift_register dut_l (
      .clk (clk),
      .rst (rst),
      .pi  (pi),
      .q   (q),
      .so  (so)
   );

   shift_register #(
      .WIDTH       (16),
      .RESET_VALUE (16'h8001),
      .SHIFT_LEFT  (1'b0)
   ) dut_r (
      .clk (clk),
      .rst (rst_r),
      .pi  (pi_r),
      .q   (q_r),
      .so  (so_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_q;
      logic [15:0] load_v;
      logic        pat [4];
      logic [15:0] pat_q [4];

      pat   = '{1'b1, 1'b0, 1'b1, 1'b1};
      pat_q = '{16'h0001, 16'h0002, 16'h0005, 16'h000B};
      rst = 1'b1; pi = 1'b1; rst_r = 1'b1; pi_r = 1'b0;

      // Long reset with pi high, then pi low while still in reset.
      for (int k = 1; k <= 35; k++) begin
         step();
         check($sformatf("rst_q_%0d", k), 32'(q), 32'h0000);
         check($sformatf("rst_so_%0d", k), 32'(so), 32'h0);
      end
      pi = 1'b0;
      step();
      check("rst_q_pi0", 32'(q), 32'h0000);
      check("rst_so_pi0", 32'(so), 32'h0);

      // Fill with ones.
      rst = 1'b0; pi = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_q = 16'((32'h1 << k) - 1);
         check($sformatf("fill_q_%0d", k), 32'(q), 32'(exp_q));
         check($sformatf("fill_so_%0d", k), 32'(so), 32'h0);
      end

      // Drain with zeros; edge 17 sees the first 1 on so.
      pi = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_q = 16'(32'hFFFF << k);
         check($sformatf("drain_q_%0d", k), 32'(q), 32'(exp_q));
         check($sformatf("drain_so_%0d", k), 32'(so), 32'h1);
      end
      step();
      check("drain_q_end", 32'(q), 32'h0000);
      check("drain_so_end", 32'(so), 32'h0);

      // Pattern 1,0,1,1 then zeros: q[3:0]=1011 after 4 edges, exits so at edges 17..20.
      for (int k = 1; k <= 20; k++) begin
         pi = (k <= 4) ? pat[k-1] : 1'b0;
         step();
         if (k <= 4) check($sformatf("pat_q_%0d", k), 32'(q), 32'(pat_q[k-1]));
         else begin
            exp_q = 16'(32'h000B << (k - 4));
            check($sformatf("pat_q_%0d", k), 32'(q), 32'(exp_q));
         end
         check($sformatf("pat_so_%0d", k), 32'(so), (k <= 16) ? 32'h0 : 32'(pat[k-17]));
      end

      // Load A5A5, reset for one cycle, then resume from zero.
      load_v = 16'hA5A5;
      for (int i = 0; i < 16; i++) begin
         pi = load_v[15-i];
         step();
      end
      check("load_q", 32'(q), 32'hA5A5);
      check("load_so", 32'(so), 32'h0);
      rst = 1'b1; pi = 1'b1;
      step();
      check("mid_rst_q", 32'(q), 32'h0000);
      check("mid_rst_so", 32'(so), 32'h0);
      rst = 1'b0;
      step();
      check("resume_q", 32'(q), 32'h0001);
      check("resume_so", 32'(so), 32'h0);

      // Right-shifting variant with a non-zero reset value.
      step();
      check("r_rst_q", 32'(q_r), 32'h8001);
      check("r_rst_so", 32'(so_r), 32'h0);
      rst_r = 1'b0; pi_r = 1'b0;
      step();
      check("r_shift0_q", 32'(q_r), 32'h4000);
      check("r_shift0_so", 32'(so_r), 32'h1);
      pi_r = 1'b1;
      step();
      check("r_shift1_q", 32'(q_r), 32'hA000);
      check("r_shift1_so", 32'(so_r), 32'h0);
      pi_r = 1'b0;
      step();
      check("r_shift2_q", 32'(q_r), 32'h5000);
      check("r_shift2_so", 32'(so_r), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
